// File: rtl/pair_shuffle_map.sv
// Card-flip board generator: builds a pair layout (each symbol twice) and
// permutes it with a Fisher-Yates shuffle driven by a 16-bit LFSR.
module pair_shuffle_map #(
    parameter int          PAIRS = 8,
    parameter int          SYM_W = 3,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       seed_load,
    input  logic [15:0]                seed_in,
    output logic                       busy,
    output logic                       done,
    output logic [2*PAIRS*SYM_W-1:0]   map
);
    localparam int SLOTS = 2 * PAIRS;
    localparam int IDX_W = $clog2(SLOTS);

    typedef enum logic [2:0] {IDLE, INIT, PICK, SWAP, COMMIT} state_t;

    state_t                 state_q, state_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [SYM_W-1:0]       work_q [SLOTS];
    logic [SYM_W-1:0]       work_d [SLOTS];
    logic [IDX_W-1:0]       i_q, i_d;
    logic [IDX_W-1:0]       j_q, j_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [SLOTS*SYM_W-1:0] map_q, map_d;
    logic [IDX_W-1:0]       mask_s;
    logic [IDX_W-1:0]       cand_s;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Smallest all-ones value covering v, so draws reject with probability < 1/2
    function automatic logic [IDX_W-1:0] bit_smear(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] m;
        m = v;
        for (int b = 1; b < IDX_W; b++) begin
            m = m | (m >> b);
        end
        return m;
    endfunction

    // LFSR free-runs in every state; a seed load overrides the shift
    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
        if (seed_load) begin
            lfsr_d = (seed_in == 16'h0000) ? SEED : seed_in;
        end else begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    // Shuffle sequencing and work-array updates
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        work_d  = work_q;
        mask_s  = bit_smear(i_q);
        cand_s  = lfsr_q[IDX_W-1:0] & mask_s;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = INIT;
                end else begin
                    state_d = IDLE;
                end
            end
            INIT: begin
                for (int k = 0; k < SLOTS; k++) begin
                    work_d[k] = SYM_W'(k >> 1);
                end
                i_d     = IDX_W'(SLOTS - 1);
                state_d = PICK;
            end
            PICK: begin
                if (cand_s <= i_q) begin
                    j_d     = cand_s;
                    state_d = SWAP;
                end else begin
                    state_d = PICK;
                end
            end
            SWAP: begin
                work_d[i_q] = work_q[j_q];
                work_d[j_q] = work_q[i_q];
                if (i_q == IDX_W'(1)) begin
                    state_d = COMMIT;
                end else begin
                    i_d     = i_q - IDX_W'(1);
                    state_d = PICK;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output registers; map is loaded together with the done pulse so the
    // consumer sees the finished layout in the same cycle done is high
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_d == COMMIT);
        map_d  = map_q;
        if (state_d == COMMIT) begin
            for (int k = 0; k < SLOTS; k++) begin
                map_d[k*SYM_W +: SYM_W] = work_d[k];
            end
        end else begin
            map_d = map_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            i_q     <= {IDX_W{1'b0}};
            j_q     <= {IDX_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            map_q   <= {(SLOTS*SYM_W){1'b0}};
            for (int k = 0; k < SLOTS; k++) begin
                work_q[k] <= {SYM_W{1'b0}};
            end
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            i_q     <= i_d;
            j_q     <= j_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            map_q   <= map_d;
            work_q  <= work_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign map  = map_q;

endmodule

// File: tb/tb_pair_shuffle_map.sv
// Directed bench for pair_shuffle_map: three instances (8, 2 and 12 pairs)
// checked for reset values, LFSR seeding, pair validity, latency and reproducibility.
module tb_pair_shuffle_map;
    logic        clk = 1'b0;
    logic        reset;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        start8, start2, start12;
    logic        busy8, busy2, busy12;
    logic        done8, done2, done12;
    logic [47:0] map8;
    logic [3:0]  map2;
    logic [95:0] map12;

    int vectors = 0;
    int miscompares = 0;

    pair_shuffle_map #(.PAIRS(8), .SYM_W(3), .SEED(16'hACE1)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .seed_load(seed_load),
        .seed_in(seed_in), .busy(busy8), .done(done8), .map(map8));

    pair_shuffle_map #(.PAIRS(2), .SYM_W(1), .SEED(16'hACE1)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .seed_load(seed_load),
        .seed_in(seed_in), .busy(busy2), .done(done2), .map(map2));

    pair_shuffle_map #(.PAIRS(12), .SYM_W(4), .SEED(16'hACE1)) dut12 (
        .clk(clk), .reset(reset), .start(start12), .seed_load(seed_load),
        .seed_in(seed_in), .busy(busy12), .done(done12), .map(map12));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic busy_of(input int w);
        case (w)
            0:       return busy8;
            1:       return busy2;
            default: return busy12;
        endcase
    endfunction

    function automatic logic done_of(input int w);
        case (w)
            0:       return done8;
            1:       return done2;
            default: return done12;
        endcase
    endfunction

    function automatic logic [127:0] map_of(input int w);
        case (w)
            0:       return 128'(map8);
            1:       return 128'(map2);
            default: return 128'(map12);
        endcase
    endfunction

    function automatic bit pairs_ok(input logic [127:0] m, input int pairs, input int sym_w);
        int cnt [64];
        int v;
        for (int s = 0; s < 64; s++) cnt[s] = 0;
        for (int k = 0; k < 2 * pairs; k++) begin
            v = 0;
            for (int b = 0; b < sym_w; b++) v = v | (int'(m[k*sym_w + b]) << b);
            if (v >= pairs) return 1'b0;
            cnt[v]++;
        end
        for (int s = 0; s < pairs; s++) begin
            if (cnt[s] != 2) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            0:       start8  = v;
            1:       start2  = v;
            default: start12 = v;
        endcase
    endtask

    // Starts instance w, waits (bounded) for done, then watches 20 idle cycles.
    task automatic run(input int w, input bit poke, output int lat, output int dones,
                       output int bad_chg, output logic busy_after, output logic [127:0] m_out);
        logic [127:0] prev;
        int c;
        prev = map_of(w);
        set_start(w, 1'b1);
        tick();
        set_start(w, 1'b0);
        lat = 0; dones = 0; bad_chg = 0; c = 0;
        while (dones == 0 && c < 1000) begin
            if (busy_of(w)) lat++;
            if (done_of(w)) dones++;
            if (map_of(w) !== prev && !done_of(w)) bad_chg++;
            prev = map_of(w);
            c++;
            if (dones == 0) begin
                if (poke && (c == 5 || c == 10)) set_start(w, 1'b1);
                tick();
                set_start(w, 1'b0);
            end
        end
        m_out = map_of(w);
        tick();
        busy_after = busy_of(w);
        for (int t = 0; t < 20; t++) begin
            if (done_of(w)) dones++;
            if (map_of(w) !== prev) bad_chg++;
            tick();
        end
    endtask

    task automatic load_seed(input logic [15:0] s);
        seed_load = 1'b1;
        seed_in   = s;
        tick();
        seed_load = 1'b0;
        seed_in   = 16'h0000;
    endtask

    initial begin
        int lat, dones, bad, ndone;
        logic ba;
        logic [127:0] m, map_a, map_b, map_c;

        reset = 1'b1; seed_load = 1'b0; seed_in = 16'h0000;
        start8 = 1'b0; start2 = 1'b0; start12 = 1'b0;
        #12;
        chk("rst_busy", 128'(busy8), 128'd0);
        chk("rst_done", 128'(done8), 128'd0);
        chk("rst_map", 128'(map8), 128'd0);
        reset = 1'b0;
        #1;
        chk("rst_lfsr", 128'(dut8.lfsr_q), 128'h0ACE1);
        tick();
        chk("lfsr_step", 128'(dut8.lfsr_q), 128'h059C3);

        // Basic shuffle from seed 1234, start on the cycle after the load
        load_seed(16'h1234);
        chk("seed_1234", 128'(dut8.lfsr_q), 128'h01234);
        run(0, 1'b0, lat, dones, bad, ba, map_a);
        chk("basic_pairs", 128'(pairs_ok(map_a, 8, 3)), 128'd1);
        chk("basic_dones", 128'(dones), 128'd1);
        chk("basic_lat_min", 128'(lat >= 32), 128'd1);
        chk("basic_lat_max", 128'(lat <= 200), 128'd1);
        chk("basic_busy_after", 128'(ba), 128'd0);
        chk("basic_map_stable", 128'(bad), 128'd0);

        // Same seed and timing reproduces the map; another seed differs
        load_seed(16'h1234);
        run(0, 1'b0, lat, dones, bad, ba, map_b);
        chk("repro_same", map_b, map_a);
        load_seed(16'h5678);
        run(0, 1'b0, lat, dones, bad, ba, map_c);
        chk("seed5678_pairs", 128'(pairs_ok(map_c, 8, 3)), 128'd1);
        chk("seed5678_differs", 128'(map_c !== map_a), 128'd1);

        // Zero seed falls back to the default seed
        load_seed(16'h0000);
        chk("zero_seed", 128'(dut8.lfsr_q), 128'h0ACE1);
        run(0, 1'b0, lat, dones, bad, ba, m);
        chk("zero_pairs", 128'(pairs_ok(m, 8, 3)), 128'd1);

        // Starts while busy are ignored
        run(0, 1'b1, lat, dones, bad, ba, m);
        chk("busy_start_dones", 128'(dones), 128'd1);
        chk("busy_start_map_chg", 128'(bad), 128'd0);
        chk("busy_start_pairs", 128'(pairs_ok(m, 8, 3)), 128'd1);

        // Asynchronous reset in the middle of a shuffle
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (6) tick();
        chk("mid_busy", 128'(busy8), 128'd1);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_busy", 128'(busy8), 128'd0);
        chk("mid_rst_done", 128'(done8), 128'd0);
        chk("mid_rst_map", 128'(map8), 128'd0);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_lfsr", 128'(dut8.lfsr_q), 128'h0ACE1);
        ndone = 0;
        for (int t = 0; t < 100; t++) begin
            tick();
            if (done8) ndone++;
        end
        chk("mid_rst_no_done", 128'(ndone), 128'd0);
        chk("mid_rst_map_zero", 128'(map8), 128'd0);
        run(0, 1'b0, lat, dones, bad, ba, m);
        chk("restart_pairs", 128'(pairs_ok(m, 8, 3)), 128'd1);
        chk("restart_dones", 128'(dones), 128'd1);

        // Parameter sweep
        run(1, 1'b0, lat, dones, bad, ba, m);
        chk("p2_pairs", 128'(pairs_ok(m, 2, 1)), 128'd1);
        chk("p2_dones", 128'(dones), 128'd1);
        chk("p2_lat_min", 128'(lat >= 8), 128'd1);
        run(2, 1'b0, lat, dones, bad, ba, m);
        chk("p12_pairs", 128'(pairs_ok(m, 12, 4)), 128'd1);
        chk("p12_dones", 128'(dones), 128'd1);
        chk("p12_lat_min", 128'(lat >= 48), 128'd1);
        chk("p12_lat_max", 128'(lat <= 400), 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
